// File: rtl/aes_key_expand.sv
// AES-128 key schedule generator.
// Produces round keys 0..NR into an internal register file that the cipher
// datapath reads by index. SubWord is evaluated one byte per cycle through a
// single S-box instance, so each round takes 4 SUB cycles plus 1 MIX cycle.
//
// Handshake: iStart is a request that is accepted only on an edge where the
// FSM is IDLE. oBusy is high from the accept edge through the edge that
// writes the last round key. oDone pulses for one cycle after that edge.
// oKeyValid then stays high until the next accepted iStart or a reset.

module aes_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  // Forward S-box table. Entry 0 sits in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Table lookup: byte i lives at bits [2047-8*i -: 8].
  always_comb begin
    out_o = SBOX_TABLE[(11'd2047 - {in_i, 3'b000}) -: 8];
  end

endmodule

module aes_key_expand #(
  parameter int NR = 10
) (
  input  logic         iClk,
  input  logic         iRst,
  input  logic         iStart,
  input  logic [127:0] iKey,
  input  logic [3:0]   iRoundIdx,
  output logic [127:0] oRoundKey,
  output logic         oBusy,
  output logic         oDone,
  output logic         oKeyValid
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SUB  = 2'd1,
    S_MIX  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [127:0]  rk_q [0:NR];
  logic [31:0]   w_q  [0:3];
  logic [3:0]    rnd_q;
  logic [1:0]    bc_q;
  logic [23:0]   sub_q;
  logic [7:0]    rcon_q;
  logic          done_q;
  logic          valid_q;

  logic          load_key;
  logic          cap_en;
  logic          mix_en;
  logic          last_rnd;
  logic [7:0]    sbox_in;
  logic [7:0]    sbox_out;
  logic [31:0]   t_d;
  logic [31:0]   wn_d [0:3];
  logic [7:0]    rcon_d;

  assign last_rnd = (rnd_q == 4'(NR));

  // State register.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and datapath enables.
  always_comb begin
    state_d  = state_q;
    load_key = 1'b0;
    cap_en   = 1'b0;
    mix_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (iStart) begin
          load_key = 1'b1;
          state_d  = S_SUB;
        end
      end
      S_SUB: begin
        cap_en = 1'b1;
        if (bc_q == 2'd3) begin
          state_d = S_MIX;
        end
      end
      S_MIX: begin
        mix_en  = 1'b1;
        state_d = last_rnd ? S_IDLE : S_SUB;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // S-box input: one byte of RotWord(w3) per cycle. The last byte is only
  // captured into the 24-bit register's place by being looked up again
  // during MIX, so MIX presents w3[31:24] to the S-box directly.
  always_comb begin
    sbox_in = 8'h00;
    if (state_q == S_MIX) begin
      sbox_in = w_q[3][31:24];
    end else begin
      case (bc_q)
        2'd0: sbox_in = w_q[3][23:16];
        2'd1: sbox_in = w_q[3][15:8];
        2'd2: sbox_in = w_q[3][7:0];
        2'd3: sbox_in = w_q[3][31:24];
        default: sbox_in = 8'h00;
      endcase
    end
  end

  aes_sbox u_sbox (
    .in_i  (sbox_in),
    .out_o (sbox_out)
  );

  // Round word mixing and Rcon xtime step.
  always_comb begin
    t_d     = {sub_q, sbox_out} ^ {rcon_q, 24'h000000};
    wn_d[0] = w_q[0] ^ t_d;
    wn_d[1] = w_q[1] ^ wn_d[0];
    wn_d[2] = w_q[2] ^ wn_d[1];
    wn_d[3] = w_q[3] ^ wn_d[2];
    rcon_d  = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
  end

  // Datapath registers: key load, byte capture, round write-back.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      for (int i = 0; i <= NR; i++) begin
        rk_q[i] <= '0;
      end
      for (int i = 0; i < 4; i++) begin
        w_q[i] <= '0;
      end
      rnd_q   <= '0;
      bc_q    <= '0;
      sub_q   <= '0;
      rcon_q  <= 8'h01;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load_key) begin
        rk_q[0] <= iKey;
        w_q[0]  <= iKey[127:96];
        w_q[1]  <= iKey[95:64];
        w_q[2]  <= iKey[63:32];
        w_q[3]  <= iKey[31:0];
        rnd_q   <= 4'd1;
        bc_q    <= 2'd0;
        rcon_q  <= 8'h01;
        valid_q <= 1'b0;
      end
      if (cap_en) begin
        case (bc_q)
          2'd0: sub_q[23:16] <= sbox_out;
          2'd1: sub_q[15:8]  <= sbox_out;
          2'd2: sub_q[7:0]   <= sbox_out;
          default: ;
        endcase
        bc_q <= bc_q + 2'd1;
      end
      if (mix_en) begin
        rk_q[rnd_q] <= {wn_d[0], wn_d[1], wn_d[2], wn_d[3]};
        for (int i = 0; i < 4; i++) begin
          w_q[i] <= wn_d[i];
        end
        rcon_q <= rcon_d;
        bc_q   <= 2'd0;
        if (last_rnd) begin
          done_q  <= 1'b1;
          valid_q <= 1'b1;
        end else begin
          rnd_q <= rnd_q + 4'd1;
        end
      end
    end
  end

  // Combinational read port; indices past the last round read zero.
  always_comb begin
    oRoundKey = '0;
    if (iRoundIdx <= 4'(NR)) begin
      oRoundKey = rk_q[iRoundIdx];
    end
  end

  assign oBusy     = (state_q != S_IDLE);
  assign oDone     = done_q;
  assign oKeyValid = valid_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Testbench for aes_key_expand: reference key schedule built from GF(2^8)
// arithmetic, fixed FIPS-197 vectors, random keys, busy/reset corner cases.

module tb_aes_key_expand;

  logic         iClk;
  logic         iRst;
  logic         iStart;
  logic [127:0] iKey;
  logic [3:0]   iRoundIdx;
  logic [127:0] oRoundKey;
  logic         oBusy;
  logic         oDone;
  logic         oKeyValid;

  int tests_run;
  int tests_failed;

  logic [7:0]   sbox_tab [256];
  logic [127:0] ref_rk [11];
  logic [127:0] exp_q [$];

  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  aes_key_expand #(.NR(10)) dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .iStart    (iStart),
    .iKey      (iKey),
    .iRoundIdx (iRoundIdx),
    .oRoundKey (oRoundKey),
    .oBusy     (oBusy),
    .oDone     (oDone),
    .oKeyValid (oKeyValid)
  );

  // Clock.
  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  task automatic init_sbox();
    logic [7:0] inv;
    logic [7:0] b;
    for (int v = 0; v < 256; v++) begin
      b   = 8'(v);
      inv = 8'h00;
      if (b != 8'h00) begin
        inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gmul(inv, b);
      end
      sbox_tab[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                    ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand_ref(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_tab[tmp[31:24]], sbox_tab[tmp[23:16]],
               sbox_tab[tmp[15:8]], sbox_tab[tmp[7:0]]};
        tmp = tmp ^ {rc, 24'h000000};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // Call away from a clock edge; returns #1 after the accept edge.
  task automatic start_key(input logic [127:0] key);
    iStart = 1'b1;
    iKey   = key;
    @(posedge iClk);
    #1;
    iStart = 1'b0;
  endtask

  // Returns the number of edges until oDone is seen, or -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge iClk);
      #1;
      if (oDone) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic read_idx(input logic [3:0] idx, output logic [127:0] val);
    iRoundIdx = idx;
    #1;
    val = oRoundKey;
  endtask

  // Queue all model round keys then sweep the read port against them.
  task automatic check_all(input logic [127:0] key, input string tag);
    logic [127:0] got;
    expand_ref(key);
    for (int r = 0; r < 11; r++) exp_q.push_back(ref_rk[r]);
    for (int r = 0; r < 11; r++) begin
      read_idx(4'(r), got);
      check($sformatf("%s_rk%0d", tag, r), got, exp_q.pop_front());
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    logic [127:0] got;
    logic [127:0] key_a;
    logic [127:0] key_b;

    tests_run    = 0;
    tests_failed = 0;
    iRst      = 1'b1;
    iStart    = 1'b0;
    iKey      = '0;
    iRoundIdx = 4'd0;
    init_sbox();

    repeat (3) @(posedge iClk);
    @(negedge iClk);
    iRst = 1'b0;

    // Reset state.
    check("rst_busy",  128'(oBusy),     128'd0);
    check("rst_done",  128'(oDone),     128'd0);
    check("rst_valid", 128'(oKeyValid), 128'd0);
    read_idx(4'd0, got);
    check("rst_rk0", got, 128'd0);

    // FIPS-197 key with latency check.
    start_key(FIPS_KEY);
    read_idx(4'd0, got);
    check("fips_rk0_early", got, FIPS_KEY);
    check("fips_busy", 128'(oBusy), 128'd1);
    wait_done(lat);
    check("fips_latency", 128'(lat), 128'd50);
    check("fips_valid", 128'(oKeyValid), 128'd1);
    check("fips_busy_end", 128'(oBusy), 128'd0);
    @(posedge iClk);
    #1;
    check("fips_done_width", 128'(oDone), 128'd0);
    read_idx(4'd1, got);
    check("fips_rk1", got, FIPS_RK1);
    read_idx(4'd9, got);
    check("fips_rk9_rcon_wrap", got, FIPS_RK9);
    read_idx(4'd10, got);
    check("fips_rk10", got, FIPS_RK10);
    read_idx(4'd11, got);
    check("idx11", got, 128'd0);
    read_idx(4'd15, got);
    check("idx15", got, 128'd0);
    check_all(FIPS_KEY, "fips");

    // Zero key.
    start_key(128'd0);
    wait_done(lat);
    check("zero_latency", 128'(lat), 128'd50);
    read_idx(4'd0, got);
    check("zero_rk0", got, 128'd0);
    read_idx(4'd1, got);
    check("zero_rk1", got, ZERO_RK1);
    read_idx(4'd10, got);
    check("zero_rk10", got, ZERO_RK10);

    // Start while busy is ignored.
    key_a = {$urandom, $urandom, $urandom, $urandom};
    key_b = ~key_a;
    start_key(key_a);
    repeat (20) @(posedge iClk);
    #1;
    start_key(key_b);
    wait_done(lat);
    check("busy_start_latency", 128'(lat), 128'd29);

    // Back-to-back: accept a new key on the edge right after done.
    start_key(key_b);
    check("b2b_valid_fall", 128'(oKeyValid), 128'd0);
    check("b2b_busy", 128'(oBusy), 128'd1);
    wait_done(lat);
    check("b2b_latency", 128'(lat), 128'd50);
    check_all(key_b, "b2b");

    // Reset mid-expansion, between edges.
    start_key(FIPS_KEY);
    iRoundIdx = 4'd0;
    repeat (23) @(posedge iClk);
    #2;
    iRst = 1'b1;
    #1;
    check("mid_rst_busy",  128'(oBusy),     128'd0);
    check("mid_rst_valid", 128'(oKeyValid), 128'd0);
    check("mid_rst_done",  128'(oDone),     128'd0);
    check("mid_rst_rk0",   oRoundKey,       128'd0);
    #3;
    iRst = 1'b0;
    start_key(FIPS_KEY);
    wait_done(lat);
    check("restart_latency", 128'(lat), 128'd50);
    read_idx(4'd10, got);
    check("restart_rk10", got, FIPS_RK10);
    check_all(FIPS_KEY, "restart");

    // Random keys.
    for (int k = 0; k < 5; k++) begin
      key_a = {$urandom, $urandom, $urandom, $urandom};
      start_key(key_a);
      wait_done(lat);
      check($sformatf("rand%0d_latency", k), 128'(lat), 128'd50);
      check_all(key_a, $sformatf("rand%0d", k));
      read_idx(4'(11 + $urandom_range(0, 4)), got);
      check($sformatf("rand%0d_oob", k), got, 128'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
